gpio_irq_lbus: RTL and testbench



---
 rtl/gpio_irq_lbus_if.sv | 14 +
 rtl/gpio_irq_lbus.sv | 127 ++++++++++++
 tb/tb_gpio_irq_lbus.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/gpio_irq_lbus_if.sv
// Local-bus slave port for the GPIO edge-interrupt block: byte-offset
// address, write/read strobes, write data and combinational read data.
interface gpio_irq_lbus_if #(
    parameter int NUM = 10
);
    logic           lb_wr;
    logic           lb_rd;
    logic [7:0]     lb_addr;
    logic [NUM-1:0] lb_wdata;
    logic [NUM-1:0] rdata;

    modport master (output lb_wr, lb_rd, lb_addr, lb_wdata, input rdata);
    modport slave  (input lb_wr, lb_rd, lb_addr, lb_wdata, output rdata);
endinterface

// File: rtl/gpio_irq_lbus.sv
// GPIO edge-interrupt slave: synchronises and debounces raw pin levels,
// latches enabled rising/falling edges into PENDING and drives a level irq.

// Per-pin debounce: accepts a new synchronised level once it has persisted
// for DEB_CNT prescaler ticks; any return to the old level restarts the count.
module gpio_irq_deb #(
    parameter int DEB_CNT = 4
) (
    input  logic lb_clk,
    input  logic rst,
    input  logic tick,
    input  logic s,
    output logic level,
    output logic acc
);
    logic [3:0] cnt;

    // Accept pulse is high on the cycle whose edge commits the new level.
    assign acc = (s != level) && tick && (cnt == 4'(DEB_CNT - 1));

    // Count persistence ticks and commit the level when the count completes.
    always_ff @(posedge lb_clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (s == level) begin
            cnt <= '0;
        end else if (acc) begin
            cnt   <= '0;
            level <= s;
        end else if (tick) begin
            cnt <= cnt + 4'd1;
        end
    end
endmodule

module gpio_irq_lbus #(
    parameter int NUM     = 10,
    parameter int DIV     = 1000,
    parameter int DEB_CNT = 4
) (
    input  logic                  lb_clk,
    input  logic                  rst,
    gpio_irq_lbus_if.slave        xt_lb,
    input  logic [NUM-1:0]        gpio_in,
    output logic                  irq
);
    localparam logic [7:0] A_RISE = 8'h04;
    localparam logic [7:0] A_FALL = 8'h08;
    localparam logic [7:0] A_PEND = 8'h0C;
    localparam logic [7:0] A_LVL  = 8'h10;

    logic [NUM-1:0] sync1, sync2;
    logic [15:0]    pcnt;
    logic           tick;
    logic [NUM-1:0] level, acc, set;
    logic [NUM-1:0] rise_en, fall_en, pend;
    logic [NUM-1:0] w1c;

    // Two-flop synchroniser; nothing else looks at gpio_in.
    always_ff @(posedge lb_clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= gpio_in;
            sync2 <= sync1;
        end
    end

    assign tick = (pcnt == 16'(DIV - 1));

    // Debounce prescaler, wraps after DIV cycles.
    always_ff @(posedge lb_clk or posedge rst) begin
        if (rst)       pcnt <= '0;
        else if (tick) pcnt <= '0;
        else           pcnt <= pcnt + 16'd1;
    end

    genvar i;
    generate
        for (i = 0; i < NUM; i++) begin : g_pin
            gpio_irq_deb #(.DEB_CNT(DEB_CNT)) u_deb (
                .lb_clk (lb_clk),
                .rst    (rst),
                .tick   (tick),
                .s      (sync2[i]),
                .level  (level[i]),
                .acc    (acc[i])
            );
            // A committed level change is a rise when the new level is 1.
            assign set[i] = acc[i] & (sync2[i] ? rise_en[i] : fall_en[i]);
        end
    endgenerate

    assign w1c = (xt_lb.lb_wr && xt_lb.lb_addr == A_PEND) ? xt_lb.lb_wdata : '0;

    // Config registers and pending bits; hardware set beats software clear.
    always_ff @(posedge lb_clk or posedge rst) begin
        if (rst) begin
            rise_en <= '0;
            fall_en <= '0;
            pend    <= '0;
        end else begin
            if (xt_lb.lb_wr && xt_lb.lb_addr == A_RISE) rise_en <= xt_lb.lb_wdata;
            if (xt_lb.lb_wr && xt_lb.lb_addr == A_FALL) fall_en <= xt_lb.lb_wdata;
            pend <= (pend & ~w1c) | set;
        end
    end

    // irq is an OR of flops only, so no pin-to-irq combinational path.
    assign irq = |pend;

    // Read mux; unmapped offsets return zero.
    always_comb begin
        xt_lb.rdata = '0;
        if (xt_lb.lb_rd) begin
            case (xt_lb.lb_addr)
                A_RISE:  xt_lb.rdata = rise_en;
                A_FALL:  xt_lb.rdata = fall_en;
                A_PEND:  xt_lb.rdata = pend;
                A_LVL:   xt_lb.rdata = level;
                default: xt_lb.rdata = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_gpio_irq_lbus.sv
// Directed bench for gpio_irq_lbus: u0 runs DIV=1/DEB_CNT=4, u1 runs
// DIV=5/DEB_CNT=2 for the prescaler cases.
module tb_gpio_irq_lbus;
    localparam int NUM = 10;

    logic lb_clk = 1'b0;
    logic rst0, rst1;
    logic [NUM-1:0] gpio0, gpio1;
    logic irq0, irq1;
    int nchk = 0;
    int nerr = 0;

    gpio_irq_lbus_if #(.NUM(NUM)) b0 ();
    gpio_irq_lbus_if #(.NUM(NUM)) b1 ();

    gpio_irq_lbus #(.NUM(NUM), .DIV(1), .DEB_CNT(4)) u0 (
        .lb_clk(lb_clk), .rst(rst0), .xt_lb(b0.slave), .gpio_in(gpio0), .irq(irq0));
    gpio_irq_lbus #(.NUM(NUM), .DIV(5), .DEB_CNT(2)) u1 (
        .lb_clk(lb_clk), .rst(rst1), .xt_lb(b1.slave), .gpio_in(gpio1), .irq(irq1));

    always #5 lb_clk = ~lb_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        bit          wr;
        logic [7:0]  a;
        logic [9:0]  d;
        logic [9:0]  exp;
        string       nm;
    } vec_t;
    vec_t tv[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic bwr(input int sel, input logic [7:0] a, input logic [9:0] d);
        @(negedge lb_clk);
        if (sel == 0) begin b0.lb_wr = 1; b0.lb_addr = a; b0.lb_wdata = d; end
        else          begin b1.lb_wr = 1; b1.lb_addr = a; b1.lb_wdata = d; end
        @(posedge lb_clk);
        #1;
        b0.lb_wr = 0;
        b1.lb_wr = 0;
    endtask

    task automatic peek(input int sel, input logic [7:0] a, output logic [9:0] d);
        if (sel == 0) begin b0.lb_addr = a; b0.lb_rd = 1; end
        else          begin b1.lb_addr = a; b1.lb_rd = 1; end
        #1;
        d = (sel == 0) ? b0.rdata : b1.rdata;
        b0.lb_rd = 0;
        b1.lb_rd = 0;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge lb_clk);
        @(negedge lb_clk);
    endtask

    logic [9:0] d;
    int n;
    bit found;

    initial begin
        tv[0]  = '{1, 8'h04, 10'h155, 10'h000, "wr_rise"};
        tv[1]  = '{1, 8'h08, 10'h2AA, 10'h000, "wr_fall"};
        tv[2]  = '{0, 8'h04, 10'h000, 10'h155, "rd_rise"};
        tv[3]  = '{0, 8'h08, 10'h000, 10'h2AA, "rd_fall"};
        tv[4]  = '{1, 8'h10, 10'h3FF, 10'h000, "wr_level_ro"};
        tv[5]  = '{1, 8'h14, 10'h3FF, 10'h000, "wr_unmapped"};
        tv[6]  = '{0, 8'h10, 10'h000, 10'h000, "rd_level"};
        tv[7]  = '{0, 8'h00, 10'h000, 10'h000, "rd_0x00"};
        tv[8]  = '{0, 8'h14, 10'h000, 10'h000, "rd_0x14"};
        tv[9]  = '{0, 8'h0C, 10'h000, 10'h000, "rd_pend"};
        tv[10] = '{0, 8'h04, 10'h000, 10'h155, "rd_rise_again"};
        tv[11] = '{0, 8'h08, 10'h000, 10'h2AA, "rd_fall_again"};

        rst0 = 1; rst1 = 1; gpio0 = '0; gpio1 = '0;
        b0.lb_wr = 0; b0.lb_rd = 0; b0.lb_addr = '0; b0.lb_wdata = '0;
        b1.lb_wr = 0; b1.lb_rd = 0; b1.lb_addr = '0; b1.lb_wdata = '0;
        #2;
        chk("reset_irq", irq0, 0);
        peek(0, 8'h0C, d); chk("reset_pend", d, 0);
        cyc(2);
        rst0 = 0; rst1 = 0;
        cyc(2);
        peek(0, 8'h10, d); chk("idle_level", d, 0);

        // Register decode table.
        for (int k = 0; k < 12; k++) begin
            if (tv[k].wr) bwr(0, tv[k].a, tv[k].d);
            else begin
                @(negedge lb_clk);
                peek(0, tv[k].a, d);
                chk(tv[k].nm, d, tv[k].exp);
            end
        end
        bwr(0, 8'h04, 10'h001);
        bwr(0, 8'h08, 10'h000);

        // Rising edge latency on pin 0: commit on the 6th edge incl. sampling edge.
        @(negedge lb_clk);
        gpio0[0] = 1;
        cyc(5);
        peek(0, 8'h10, d); chk("rise_level_early", d, 0);
        chk("rise_irq_early", irq0, 0);
        cyc(1);
        peek(0, 8'h10, d); chk("rise_level", d, 10'h001);
        peek(0, 8'h0C, d); chk("rise_pend", d, 10'h001);
        chk("rise_irq", irq0, 1);
        gpio0[0] = 0;
        cyc(10);
        peek(0, 8'h10, d); chk("release_level", d, 0);
        peek(0, 8'h0C, d); chk("release_pend_kept", d, 10'h001);
        bwr(0, 8'h0C, 10'h001);
        bwr(0, 8'h04, 10'h000);
        bwr(0, 8'h08, 10'h3FF);

        // Glitch rejection on pin 5.
        gpio0 = 10'h3FF;
        cyc(10);
        peek(0, 8'h10, d); chk("all_high_level", d, 10'h3FF);
        peek(0, 8'h0C, d); chk("all_high_pend", d, 0);
        gpio0[5] = 0;
        repeat (3) @(posedge lb_clk);
        @(negedge lb_clk);
        gpio0[5] = 1;
        cyc(10);
        peek(0, 8'h10, d); chk("glitch3_level", d, 10'h3FF);
        peek(0, 8'h0C, d); chk("glitch3_pend", d, 0);
        gpio0[5] = 0;
        repeat (10) @(posedge lb_clk);
        @(negedge lb_clk);
        peek(0, 8'h10, d); chk("drop10_level", d, 10'h3DF);
        peek(0, 8'h0C, d); chk("drop10_pend", d, 10'h020);
        gpio0[5] = 1;
        cyc(10);

        // W1C: fall on pin 0 gives PENDING=0x021.
        gpio0[0] = 0;
        cyc(10);
        peek(0, 8'h0C, d); chk("pend_021", d, 10'h021);
        bwr(0, 8'h0C, 10'h001);
        peek(0, 8'h0C, d); chk("w1c_bit0", d, 10'h020);
        chk("w1c_irq_still", irq0, 1);
        bwr(0, 8'h0C, 10'h020);
        peek(0, 8'h0C, d); chk("w1c_all", d, 0);
        chk("w1c_irq_low", irq0, 0);

        // Collision: W1C of bit 3 on the edge that sets it.
        bwr(0, 8'h08, 10'h000);
        @(negedge lb_clk);
        gpio0[3] = 0;
        cyc(10);
        bwr(0, 8'h04, 10'h008);
        @(negedge lb_clk);
        gpio0[3] = 1;
        repeat (5) @(posedge lb_clk);
        @(negedge lb_clk);
        b0.lb_wr = 1; b0.lb_addr = 8'h0C; b0.lb_wdata = 10'h008;
        @(posedge lb_clk);
        #1;
        b0.lb_wr = 0;
        @(negedge lb_clk);
        peek(0, 8'h10, d); chk("collide_level", d, 10'h3FE);
        peek(0, 8'h0C, d); chk("collide_set_wins", d, 10'h008);
        bwr(0, 8'h04, 10'h000);
        peek(0, 8'h0C, d); chk("en_clear_keeps_pend", d, 10'h008);
        bwr(0, 8'h0C, 10'h008);

        // Fill PENDING=0x3FF, then reset mid-debounce.
        bwr(0, 8'h04, 10'h3FF);
        bwr(0, 8'h08, 10'h3FF);
        @(negedge lb_clk);
        gpio0 = 10'h000;
        cyc(10);
        gpio0 = 10'h3FF;
        cyc(10);
        peek(0, 8'h0C, d); chk("pend_full", d, 10'h3FF);
        gpio0 = 10'h000;
        cyc(3);
        rst0 = 1;
        #1;
        chk("midrst_irq", irq0, 0);
        peek(0, 8'h04, d); chk("midrst_rise", d, 0);
        peek(0, 8'h08, d); chk("midrst_fall", d, 0);
        peek(0, 8'h0C, d); chk("midrst_pend", d, 0);
        peek(0, 8'h10, d); chk("midrst_level", d, 0);
        cyc(2);
        rst0 = 0;
        cyc(10);
        peek(0, 8'h10, d); chk("postrst_level", d, 0);

        // Prescaler instance: DIV=5, DEB_CNT=2.
        bwr(1, 8'h04, 10'h200);
        @(negedge lb_clk);
        gpio1[9] = 1;
        n = 0; found = 0;
        while (!found && n < 20) begin
            @(posedge lb_clk);
            n++;
            @(negedge lb_clk);
            peek(1, 8'h10, d);
            if (d[9]) found = 1;
        end
        chk("div5_level_seen", found, 1);
        chk("div5_latency_in_range", (n >= 8 && n <= 12), 1);
        peek(1, 8'h0C, d); chk("div5_pend", d, 10'h200);
        chk("div5_irq", irq1, 1);
        gpio1[8] = 1;
        repeat (4) @(posedge lb_clk);
        @(negedge lb_clk);
        gpio1[8] = 0;
        cyc(15);
        peek(1, 8'h10, d); chk("div5_pulse_rejected", d, 10'h200);
        gpio1[8] = 1;
        cyc(15);
        peek(1, 8'h10, d); chk("div5_hold_accepted", d, 10'h300);
        peek(1, 8'h0C, d); chk("div5_pend_masked", d, 10'h200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
        $finish;
    end
endmodule
